// File: rtl/conv_mdc_frame_sequencer_if.sv
// conv_mdc_frame_sequencer_if: upstream pixel stream, kernel src stream and observed kernel dst stream.
// The slave side is the sequencer; the master side is everything around it.
interface conv_mdc_frame_sequencer_if;
    logic up_valid;
    logic up_ready;
    logic kin_valid;
    logic kin_ready;
    logic kout_valid;
    logic kout_ready;

    modport master (
        output up_valid, kin_ready, kout_valid, kout_ready,
        input  up_ready, kin_valid
    );

    modport slave (
        input  up_valid, kin_ready, kout_valid, kout_ready,
        output up_ready, kin_valid
    );
endinterface

// File: rtl/conv_mdc_frame_sequencer.sv
// conv_mdc_frame_sequencer: runs one conv_mdc frame per job, admitting exactly width*height pixels
// and signalling done once as many kernel outputs have left, with a drain watchdog.
module conv_mdc_frame_sequencer #(
    parameter int unsigned DIM_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [DIM_W-1:0]          width_i,
    input  logic [DIM_W-1:0]          height_i,
    conv_mdc_frame_sequencer_if.slave strm,
    output logic                      busy_o,
    output logic                      idle_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [2*DIM_W-1:0]        in_cnt_o,
    output logic [2*DIM_W-1:0]        out_cnt_o
);
    localparam int unsigned CW  = 2 * DIM_W;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [CW-1:0]    total_q, total_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             gate, in_hs, out_hs, in_last, out_last, wd_fire;

    // The input gate is open only in RUN, which is left on the final input handshake.
    assign gate           = state_q == RUN;
    assign strm.kin_valid = gate & strm.up_valid;
    assign strm.up_ready  = gate & strm.kin_ready;
    assign in_hs          = gate & strm.up_valid & strm.kin_ready;
    assign out_hs         = (state_q == RUN || state_q == DRAIN) & strm.kout_valid & strm.kout_ready;
    assign in_last        = in_hs && (in_cnt_q + 1'b1 == total_q);
    assign out_last       = out_hs && (out_cnt_q + 1'b1 == total_q);
    assign wd_fire        = state_q == DRAIN && wd_q == WDW'(TIMEOUT);

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        total_d   = total_q;
        in_cnt_d  = in_hs ? in_cnt_q + 1'b1 : in_cnt_q;
        out_cnt_d = out_hs ? out_cnt_q + 1'b1 : out_cnt_q;
        wd_d      = (state_q == DRAIN && !out_hs) ? wd_q + 1'b1 : '0;
        err_d     = 1'b0;
        code_d    = code_q;
        case (state_q)
            IDLE: begin
                if (start_i && (width_i == '0 || height_i == '0)) begin
                    err_d  = 1'b1;
                    code_d = 2'b01;
                end else if (start_i) begin
                    w_d       = width_i;
                    h_d       = height_i;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    code_d    = 2'b00;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                total_d = CW'(w_q) * CW'(h_q);
                state_d = RUN;
            end
            RUN:     state_d = out_last ? DONE : in_last ? DRAIN : RUN;
            DRAIN:   state_d = (out_last || wd_fire) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start_i && state_q != IDLE) begin
            err_d  = 1'b1;
            code_d = 2'b10;
        end
        // A watchdog expiry outranks a simultaneous busy start in the reported code.
        if (state_q == DRAIN && !out_hs && wd_d == WDW'(TIMEOUT)) begin
            err_d  = 1'b1;
            code_d = 2'b11;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else if (clear_i) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign busy_o     = state_q != IDLE;
    assign idle_o     = state_q == IDLE;
    assign done_o     = state_q == DONE;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign in_cnt_o   = in_cnt_q;
    assign out_cnt_o  = out_cnt_q;
endmodule

// File: doc/conv_mdc_frame_sequencer.md
Name: conv_mdc_frame_sequencer

Overview:
- Sequences one conv_mdc frame per job: latches width/height on start, computes the frame pixel count, and gates the input stream into the kernel adapter so exactly width*height pixels enter.
- Counts kernel outputs and raises a single-cycle done once width*height outputs have left, with a drain watchdog.
- Sits between the HWPE engine/controller (start, clear, flags) and the conv_mdc kernel adapter's src/dst streams, replacing the adapter's ad-hoc idle/done inference.

Parameters:
DIM_W, 16, width of width_i/height_i; frame count width is 2*DIM_W
TIMEOUT, 1024, max cycles without an output handshake in DRAIN before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear, highest priority after reset
start_i  in  1  job start pulse from controller
width_i  in  DIM_W  frame width, sampled on accepted start
height_i  in  DIM_W  frame height, sampled on accepted start
up_valid_i  in  1  upstream pixel valid
up_ready_o  out  1  upstream pixel ready
kin_valid_o  out  1  pixel valid to kernel src port
kin_ready_i  in  1  kernel src ready
kout_valid_i  in  1  kernel dst valid
kout_ready_i  in  1  downstream ready on kernel dst (observed, not driven)
busy_o  out  1  job in progress
idle_o  out  1  in IDLE
done_o  out  1  one-cycle job-complete pulse
err_o  out  1  one-cycle error pulse
err_code_o  out  2  01 zero dim, 10 start while busy, 11 drain timeout; held until next accepted start/clear
in_cnt_o  out  2*DIM_W  pixels accepted this job
out_cnt_o  out  2*DIM_W  outputs observed this job

Behaviour:
- Reset: state IDLE; idle_o=1; busy_o, done_o, err_o=0; err_code_o=00; counters 0; up_ready_o=kin_valid_o=0.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE, start_i=1:
  - width_i or height_i == 0: err_o pulse next cycle, err_code_o=01, stay IDLE.
  - otherwise: latch dims, clear counters and err_code_o, go LOAD.
- LOAD (1 cycle): register total = width*height, full 2*DIM_W product, no truncation; go RUN. busy_o=1 from LOAD through DONE.
- RUN:
  - Gating (combinational): kin_valid_o = up_valid_i; up_ready_o = kin_ready_i.
  - Input handshake = up_valid_i & kin_ready_i; increments in_cnt_o.
  - On the handshake that brings in_cnt_o to total: go DRAIN. Gating closes the following cycle, so pixel total+1 is never forwarded.
- All other states: kin_valid_o=0, up_ready_o=0.
- Output counting, RUN and DRAIN: each cycle with kout_valid_i & kout_ready_i increments out_cnt_o. Outputs may overlap inputs in RUN.
- Completion: out_cnt_o reaching total in RUN or DRAIN goes to DONE. If it coincides with the final input handshake, go straight to DONE.
- Outputs beyond total are not counted and have no effect.
- DRAIN watchdog:
  - Counter cleared on DRAIN entry and on every output handshake.
  - When it reaches TIMEOUT: err_o pulse, err_code_o=11, go DONE.
- DONE (1 cycle): done_o=1, then IDLE. Counters hold their final values until the next accepted start.
- start_i outside IDLE: ignored for sequencing; err_o pulse, err_code_o=10, job continues.
- start_i in the DONE cycle: treated as busy.
- clear_i: next cycle state IDLE, counters and err_code_o cleared, done_o/err_o low. Any in-flight pixel handshake in that cycle is still counted before the clear; the clear wins.
- Reset mid-job: immediate return to reset values, no done_o.
- Latency:
  - Start to first possible forwarded pixel: 2 cycles (IDLE->LOAD->RUN).
  - Final output handshake to done_o: 1 cycle.

Test Plan:
- width=4, height=3, continuous valid/ready, kernel echoes with 2-cycle latency -> in_cnt_o=12, out_cnt_o=12; done_o single pulse one cycle after 12th output; 13th upstream pixel never sees up_ready_o=1.
- width=0, height=5 start -> err_o pulse, err_code_o=01, idle_o stays 1, no busy_o.
- width=2, height=2, kin_ready_i toggling 1010 and kout_ready_i stalls of 3 cycles -> exactly 4 input and 4 output handshakes counted, done_o after 4th output.
- width=0xFFFF, height=2 (DIM_W=16) -> total=0x1FFFE latched without truncation (check internal total / in_cnt_o progress).
- width=2, height=2, kernel emits only 3 outputs, TIMEOUT=16 -> 16 cycles after 3rd output err_o pulse, err_code_o=11, done_o next cycle, out_cnt_o=3.
- start_i mid-RUN, then clear_i mid-RUN, then rst_ni low mid-RUN -> err_code_o=10 without disruption; clear returns to IDLE with counters 0 and no done_o; reset asynchronously forces reset values.
